// File: rtl/mem_01.sv
// Dual-memory datapath: 512x8 input memory (two async read ports), 8-bit ALU, 512x8 result memory.
// Define MEM_01_EXT_ALU_EN to enable extended ALU opcodes 101/110/111 (otherwise they yield 0).
module mem_01 (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       we_mem_in,
    input  logic       we_resultado,
    input  logic [8:0] enderecoA,
    input  logic [8:0] enderecoB,
    input  logic [8:0] endereco_saida,
    input  logic [7:0] dado_in,
    input  logic [2:0] opcode,
    output logic [7:0] sdadosA,
    output logic [7:0] sdadosB,
    output logic [7:0] s_ula,
    output logic [7:0] saida
);

    logic [7:0] r_mem_in  [512];
    logic [7:0] r_mem_res [512];

    // Result memory captures the ALU value seen before the edge, even when mem_in is written in the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 512; i++) begin
                r_mem_in[i]  <= '0;
                r_mem_res[i] <= '0;
            end
        end else if (cs) begin
            if (we_mem_in)
                r_mem_in[enderecoA] <= dado_in;
            if (we_resultado)
                r_mem_res[endereco_saida] <= s_ula;
        end
    end

    always_comb begin
        sdadosA = '0;
        sdadosB = '0;
        saida   = '0;
        if (cs) begin
            sdadosA = r_mem_in[enderecoA];
            sdadosB = r_mem_in[enderecoB];
            saida   = r_mem_res[endereco_saida];
        end
    end

    always_comb begin
        s_ula = '0;
        case (opcode)
            3'b000: s_ula = sdadosA + sdadosB;
            3'b001: s_ula = sdadosA - sdadosB;
            3'b010: s_ula = sdadosA & sdadosB;
            3'b011: s_ula = sdadosA | sdadosB;
            3'b100: s_ula = sdadosA ^ sdadosB;
`ifdef MEM_01_EXT_ALU_EN
            3'b101: s_ula = ~sdadosA;
            3'b110: s_ula = {sdadosA[6:0], 1'b0};
            3'b111: s_ula = sdadosB;
`endif
            default: s_ula = '0;
        endcase
    end

endmodule

// File: tb/tb_mem_01.sv
// Randomized self-checking bench for mem_01 against an array-based reference model,
// plus directed scenarios with hand-computed expectations.
module tb_mem_01;

    logic       clk = 1'b0;
    logic       rst, cs, we_mem_in, we_resultado;
    logic [8:0] enderecoA, enderecoB, endereco_saida;
    logic [7:0] dado_in;
    logic [2:0] opcode;
    logic [7:0] sdadosA, sdadosB, s_ula, saida;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    bit          chk_en  = 0;
    logic [7:0]  m_in  [512];
    logic [7:0]  m_res [512];

    always #5 clk = ~clk;

    mem_01 dut (
        .clk(clk), .rst(rst), .cs(cs), .we_mem_in(we_mem_in), .we_resultado(we_resultado),
        .enderecoA(enderecoA), .enderecoB(enderecoB), .endereco_saida(endereco_saida),
        .dado_in(dado_in), .opcode(opcode),
        .sdadosA(sdadosA), .sdadosB(sdadosB), .s_ula(s_ula), .saida(saida)
    );

    function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
`ifdef MEM_01_EXT_ALU_EN
            3'd5: return ~a;
            3'd6: return a * 2;
            3'd7: return b;
`endif
            default: return 8'h00;
        endcase
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge; the model applies the writes the spec dictates for the pre-edge inputs.
    task automatic step();
        logic [7:0] a, b, pre_ula;
        a = cs ? m_in[enderecoA] : 8'h00;
        b = cs ? m_in[enderecoB] : 8'h00;
        pre_ula = alu_ref(opcode, a, b);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 512; i++) begin
                m_in[i]  = 8'h00;
                m_res[i] = 8'h00;
            end
        end else if (cs) begin
            if (we_mem_in)    m_in[enderecoA]       = dado_in;
            if (we_resultado) m_res[endereco_saida] = pre_ula;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [7:0] ea, eb, es;
            ea = cs ? m_in[enderecoA] : 8'h00;
            eb = cs ? m_in[enderecoB] : 8'h00;
            es = cs ? m_res[endereco_saida] : 8'h00;
            check8("model_sdadosA", sdadosA, ea);
            check8("model_sdadosB", sdadosB, eb);
            check8("model_saida",   saida,   es);
            check8("model_s_ula",   s_ula,   alu_ref(opcode, ea, eb));
        end
    end

    initial begin
        rst = 1; cs = 0; we_mem_in = 0; we_resultado = 0;
        enderecoA = '0; enderecoB = '0; endereco_saida = '0; dado_in = '0; opcode = '0;
        step();
        rst = 0;
        chk_en = 1;

        // Post-reset reads
        cs = 1; opcode = 3'd0; enderecoA = 9'd37; enderecoB = 9'd200; endereco_saida = 9'd99;
        #1;
        check8("reset_sdadosA", sdadosA, 8'h00);
        check8("reset_sdadosB", sdadosB, 8'h00);
        check8("reset_saida",   saida,   8'h00);
        check8("reset_s_ula",   s_ula,   8'h00);

        // Write 0x04 to address 0, read on both ports
        enderecoA = 9'd0; dado_in = 8'h04; we_mem_in = 1;
        step();
        we_mem_in = 0; enderecoB = 9'd0;
        #1;
        check8("wr0_sdadosA", sdadosA, 8'h04);
        check8("wr0_sdadosB", sdadosB, 8'h04);
        check8("wr0_add",     s_ula,   8'h08);

        // Subtraction wrap-around stored into result memory
        enderecoA = 9'd6; dado_in = 8'h09; we_mem_in = 1;
        step();
        we_mem_in = 0; enderecoA = 9'd0; enderecoB = 9'd6; opcode = 3'd1;
        #1;
        check8("sub_wrap_s_ula", s_ula, 8'hFB);
        we_resultado = 1; endereco_saida = 9'd2;
        step();
        we_resultado = 0;
        #1;
        check8("sub_wrap_saida", saida, 8'hFB);

        // Chip deselected: outputs zero, write blocked
        cs = 0; we_mem_in = 1; dado_in = 8'h55; enderecoA = 9'd1;
        #1;
        check8("cs0_sdadosA", sdadosA, 8'h00);
        check8("cs0_saida",   saida,   8'h00);
        step();
        we_mem_in = 0; cs = 1;
        #1;
        check8("cs0_blocked", sdadosA, 8'h00);

        // Both writes in one edge; result memory gets pre-edge sum
        enderecoA = 9'd0; enderecoB = 9'd0; opcode = 3'd0; dado_in = 8'h10;
        we_mem_in = 1; we_resultado = 1; endereco_saida = 9'd3;
        step();
        we_mem_in = 0; we_resultado = 0;
        #1;
        check8("dual_wr_saida",   saida,   8'h08);
        check8("dual_wr_sdadosA", sdadosA, 8'h10);

        // Same address on both ports during a write
        enderecoA = 9'd9; enderecoB = 9'd9; dado_in = 8'hAB; we_mem_in = 1;
        step();
        we_mem_in = 0;
        #1;
        check8("collide_A", sdadosA, 8'hAB);
        check8("collide_B", sdadosB, 8'hAB);

        // Extended opcode 101
        enderecoA = 9'd7; dado_in = 8'h0F; we_mem_in = 1;
        step();
        we_mem_in = 0; opcode = 3'd5;
        #1;
`ifdef MEM_01_EXT_ALU_EN
        check8("op101", s_ula, 8'hF0);
`else
        check8("op101", s_ula, 8'h00);
`endif

        // Randomized traffic; narrow address window most of the time to force reuse
        for (int n = 0; n < 3000; n++) begin
            rst          = ($urandom_range(0, 99) == 0);
            cs           = ($urandom_range(0, 7) != 0);
            we_mem_in    = $urandom_range(0, 1);
            we_resultado = $urandom_range(0, 1);
            opcode       = 3'($urandom_range(0, 7));
            dado_in      = 8'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                enderecoA      = 9'($urandom_range(0, 15));
                enderecoB      = 9'($urandom_range(0, 15));
                endereco_saida = 9'($urandom_range(0, 15));
            end else begin
                enderecoA      = 9'($urandom);
                enderecoB      = 9'($urandom);
                endereco_saida = 9'($urandom);
            end
            step();
        end

        // Final reset clears written contents
        rst = 0; cs = 1; we_mem_in = 1; we_resultado = 0; enderecoA = 9'd0; dado_in = 8'h5A;
        step();
        we_mem_in = 0; we_resultado = 1; endereco_saida = 9'd0; enderecoB = 9'd0; opcode = 3'd0;
        step();
        we_resultado = 0; rst = 1;
        step();
        rst = 0;
        #1;
        check8("final_reset_sdadosA", sdadosA, 8'h00);
        check8("final_reset_saida",   saida,   8'h00);

        @(negedge clk);
        #1;
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_01.md
MEM_01 -- requirements
Module: mem_01

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port cs, input, 1 bit: chip select; 1 = block enabled.
REQ-004 SHALL have port we_mem_in, input, 1 bit: write enable for the input memory.
REQ-005 SHALL have port we_resultado, input, 1 bit: write enable for the result memory.
REQ-006 SHALL have port enderecoA, input, 9 bits: input-memory port A address, used for both read and write.
REQ-007 SHALL have port enderecoB, input, 9 bits: input-memory port B read address.
REQ-008 SHALL have port endereco_saida, input, 9 bits: result-memory address, used for both read and write.
REQ-009 SHALL have port dado_in, input, 8 bits: write data for the input memory.
REQ-010 SHALL have port opcode, input, 3 bits: ALU operation select.
REQ-011 SHALL have ports sdadosA and sdadosB, outputs, 8 bits each: input-memory read data for ports A and B.
REQ-012 SHALL have port s_ula, output, 8 bits: ALU result.
REQ-013 SHALL have port saida, output, 8 bits: result-memory read data.

Function
REQ-014 SHALL contain two 512x8 arrays: mem_in (input memory) and mem_res (result memory).
REQ-015 SHALL write dado_in to mem_in[enderecoA] on a rising edge when cs=1, we_mem_in=1 and rst=0.
REQ-016 SHALL write s_ula, as evaluated before the edge, to mem_res[endereco_saida] on a rising edge when cs=1, we_resultado=1 and rst=0.
REQ-017 SHALL read asynchronously when cs=1: sdadosA = mem_in[enderecoA], sdadosB = mem_in[enderecoB], saida = mem_res[endereco_saida].
REQ-018 SHALL drive sdadosA, sdadosB and saida to 0, and block all writes, when cs=0.
REQ-019 SHALL compute s_ula combinationally from A = sdadosA and B = sdadosB, using modulo-256 arithmetic with no carry or flag outputs:
- 000: A+B
- 001: A-B
- 010: A&B
- 011: A|B
- 100: A^B
REQ-020 SHALL make new data visible on the read outputs immediately after the writing edge (zero-cycle read latency).
REQ-021 SHALL perform both writes in the same edge when both enables are set; the mem_res write uses pre-edge s_ula.
REQ-022 SHALL treat a same-edge write to mem_in[enderecoA] while enderecoA=enderecoB as an ordinary write; both ports then show the new value after the edge.

Reset
REQ-023 SHALL clear every entry of mem_in and mem_res to 0 on a rising edge with rst=1.
REQ-024 SHALL give rst priority over cs and both write enables.
REQ-025 SHALL hold outputs after reset, with cs=1, at sdadosA=sdadosB=saida=0 and s_ula = opcode result of 0,0.

Configuration
REQ-026 SHALL, when macro MEM_01_EXT_ALU_EN is defined, implement the extended opcodes:
- 101: ~A
- 110: A<<1
- 111: B
REQ-027 SHALL, when MEM_01_EXT_ALU_EN is undefined, output s_ula=0 for opcodes 101, 110 and 111.

Verification
REQ-028 SHALL cover: reset, then cs=1, read any address with opcode=000 -> sdadosA=sdadosB=saida=0, s_ula=0.
REQ-029 SHALL cover: dado_in=0x04, enderecoA=0, we_mem_in=1 for one edge; then enderecoB=0 -> sdadosA=sdadosB=0x04, s_ula=0x08 (opcode 000).
REQ-030 SHALL cover: mem_in[0]=0x04 and mem_in[6]=0x09, A=0, B=6, opcode=001, we_resultado=1, endereco_saida=2 for one edge -> saida=0xFB (wrap-around).
REQ-031 SHALL cover: cs=0 with we_mem_in=1 and dado_in=0x55 at enderecoA=1, then cs=1 -> sdadosA=0x00 (write blocked); outputs read 0 while cs=0.
REQ-032 SHALL cover: both enables set in the same edge, A=B=0, mem_in[0]=0x04, dado_in=0x10, endereco_saida=3 -> mem_res[3]=0x08, mem_in[0]=0x10.
REQ-033 SHALL cover: opcode=101 with A=0x0F -> s_ula=0xF0 with MEM_01_EXT_ALU_EN defined, 0x00 without.
